// File: rtl/pc_fetch_ctrl_if.sv
// Instruction-memory request/response bus between the fetch sequencer
// (master) and the instruction memory (slave). One outstanding request:
// imem_req/imem_gnt hand off the address, imem_rvalid/imem_rdata return data.
interface pc_fetch_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: fetch sequencer around the next-PC datapath.
// Owns the PC, issues one instruction fetch at a time, buffers the returned
// word in a one-entry output register and applies redirects, dropping any
// stale in-flight response (KILL state).
// Optional feature macro: PC_MISALIGN_TRAP_EN. When defined, a redirect to a
// non word-aligned target flushes, pulses misalign_err and parks in HALT until
// reset. When undefined, the low two target bits are simply cleared.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rstn,
  pc_fetch_ctrl_if.master       imem,
  output logic                  inst_valid,
  output logic [31:0]           inst_out,
  output logic [31:0]           inst_pc,
  input  logic                  inst_ready,
  input  logic                  redir_valid,
  input  logic [31:0]           redir_pc,
  output logic [31:0]           pc_out,
  output logic                  misalign_err
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
`ifdef PC_MISALIGN_TRAP_EN
    ST_KILL = 3'd3,
    ST_HALT = 3'd4
`else
    ST_KILL = 3'd3
`endif
  } state_e;

  state_e      state_q, state_d;
  state_e      redir_next;
  logic [31:0] pc_q, pc_d;
  logic        inst_valid_q, inst_valid_d;
  logic [31:0] inst_out_q, inst_out_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        issue_ok;
  logic        redir_take;
`ifdef PC_MISALIGN_TRAP_EN
  logic        err_q, err_d;
`endif

  // Issue gating and redirect acceptance (redirects ignored in IDLE/HALT).
  always_comb begin
    issue_ok   = (state_q == ST_REQ) && (!inst_valid_q || inst_ready);
    redir_take = redir_valid &&
                 ((state_q == ST_REQ) || (state_q == ST_WAIT) || (state_q == ST_KILL));
  end

  // State after an accepted redirect: KILL whenever an old address is in flight.
  always_comb begin
    case (state_q)
      ST_REQ:  redir_next = (issue_ok && imem.imem_gnt) ? ST_KILL : ST_REQ;
      ST_WAIT: redir_next = imem.imem_rvalid ? ST_REQ : ST_KILL;
      default: redir_next = ST_KILL;
    endcase
  end

  // Next-state, PC and output-register update; redirect has top priority.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_valid_d = inst_valid_q && !inst_ready;
    inst_out_d   = inst_out_q;
    inst_pc_d    = inst_pc_q;
`ifdef PC_MISALIGN_TRAP_EN
    err_d        = 1'b0;
`endif
    if (redir_take) begin
      inst_valid_d = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
      if (redir_pc[1:0] != 2'b00) begin
        err_d   = 1'b1;
        state_d = ST_HALT;
      end else begin
        pc_d    = redir_pc & 32'hFFFF_FFFC;
        state_d = redir_next;
      end
`else
      pc_d    = redir_pc & 32'hFFFF_FFFC;
      state_d = redir_next;
`endif
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_REQ;
        ST_REQ: begin
          if (issue_ok && imem.imem_gnt) begin
            state_d = ST_WAIT;
          end else begin
            state_d = ST_REQ;
          end
        end
        ST_WAIT: begin
          if (imem.imem_rvalid) begin
            inst_out_d   = imem.imem_rdata;
            inst_pc_d    = pc_q;
            inst_valid_d = 1'b1;
            pc_d         = pc_q + 32'd4;
            state_d      = ST_REQ;
          end else begin
            state_d = ST_WAIT;
          end
        end
        ST_KILL: begin
          if (imem.imem_rvalid) begin
            state_d = ST_REQ;
          end else begin
            state_d = ST_KILL;
          end
        end
`ifdef PC_MISALIGN_TRAP_EN
        ST_HALT: state_d = ST_HALT;
`endif
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      inst_valid_q <= 1'b0;
      inst_out_q   <= 32'h0000_0000;
      inst_pc_q    <= 32'h0000_0000;
`ifdef PC_MISALIGN_TRAP_EN
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_valid_q <= inst_valid_d;
      inst_out_q   <= inst_out_d;
      inst_pc_q    <= inst_pc_d;
`ifdef PC_MISALIGN_TRAP_EN
      err_q        <= err_d;
`endif
    end
  end

  assign imem.imem_req  = issue_ok;
  assign imem.imem_addr = pc_q;
  assign inst_valid     = inst_valid_q;
  assign inst_out       = inst_out_q;
  assign inst_pc        = inst_pc_q;
  assign pc_out         = pc_q;
`ifdef PC_MISALIGN_TRAP_EN
  assign misalign_err   = err_q;
`else
  assign misalign_err   = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Testbench for pc_fetch_ctrl: memory model plus scoreboard of expected
// grant addresses and delivered instructions; one task per scenario.
module tb_pc_fetch_ctrl;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  logic        clk;
  logic        rstn;
  logic        inst_ready;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic [31:0] pc_out;
  logic        misalign_err;
  logic        gnt_en;
  logic        rvalid_en;
  logic        pend_q;
  logic [31:0] pend_addr_q;

  // second instance: RESET_PC at the top of the address space
  logic        inst_valid2;
  logic [31:0] inst_out2;
  logic [31:0] inst_pc2;
  logic [31:0] pc_out2;
  logic        misalign_err2;
  logic        pend2_q;
  logic [31:0] pend2_addr_q;

  int n_checks;
  int n_pass;

  logic [31:0] addr_q[$];
  exp_t        inst_q[$];

  pc_fetch_ctrl_if bus ();
  pc_fetch_ctrl_if bus2 ();

  pc_fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rstn(rstn), .imem(bus.master),
    .inst_valid(inst_valid), .inst_out(inst_out), .inst_pc(inst_pc),
    .inst_ready(inst_ready), .redir_valid(redir_valid), .redir_pc(redir_pc),
    .pc_out(pc_out), .misalign_err(misalign_err)
  );

  pc_fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rstn(rstn), .imem(bus2.master),
    .inst_valid(inst_valid2), .inst_out(inst_out2), .inst_pc(inst_pc2),
    .inst_ready(1'b1), .redir_valid(1'b0), .redir_pc(32'h0000_0000),
    .pc_out(pc_out2), .misalign_err(misalign_err2)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a ^ 32'hC0DE_0000) + 32'h0000_1357;
  endfunction

  // Memory model: grant in the request cycle, respond once rvalid_en allows.
  assign bus.imem_gnt    = bus.imem_req & gnt_en;
  assign bus.imem_rvalid = pend_q & rvalid_en;
  assign bus.imem_rdata  = mem_word(pend_addr_q);
  assign bus2.imem_gnt    = bus2.imem_req;
  assign bus2.imem_rvalid = pend2_q;
  assign bus2.imem_rdata  = mem_word(pend2_addr_q);

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_q  <= 1'b0;
      pend2_q <= 1'b0;
    end else begin
      if (bus.imem_req && bus.imem_gnt) begin
        pend_q      <= 1'b1;
        pend_addr_q <= bus.imem_addr;
      end else if (bus.imem_rvalid) begin
        pend_q <= 1'b0;
      end
      if (bus2.imem_req && bus2.imem_gnt) begin
        pend2_q      <= 1'b1;
        pend2_addr_q <= bus2.imem_addr;
      end else if (bus2.imem_rvalid) begin
        pend2_q <= 1'b0;
      end
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Scoreboard monitor: check grant addresses and consumed instructions.
  initial begin
    logic [31:0] a;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (rstn && bus.imem_req && bus.imem_gnt && addr_q.size() > 0) begin
        a = addr_q.pop_front();
        n_checks++;
        if (bus.imem_addr !== a) $display("FAIL grant_addr got %h exp %h", bus.imem_addr, a);
        else n_pass++;
      end
      if (rstn && inst_valid && inst_ready && inst_q.size() > 0) begin
        e = inst_q.pop_front();
        n_checks++;
        if (inst_pc !== e.pc) $display("FAIL inst_pc got %h exp %h", inst_pc, e.pc);
        else n_pass++;
        n_checks++;
        if (inst_out !== e.data) $display("FAIL inst_out got %h exp %h", inst_out, e.data);
        else n_pass++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  function automatic exp_t mk(input logic [31:0] p);
    exp_t e;
    e.pc   = p;
    e.data = mem_word(p);
    return e;
  endfunction

  task automatic do_reset(input logic rdy);
    @(posedge clk); #2;
    rstn        = 1'b0;
    redir_valid = 1'b0;
    redir_pc    = 32'h0000_0000;
    inst_ready  = rdy;
    gnt_en      = 1'b1;
    rvalid_en   = 1'b1;
    addr_q.delete();
    inst_q.delete();
    @(posedge clk); #2;
    rstn = 1'b1;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (addr_q.size() == 0 && inst_q.size() == 0) break;
      @(posedge clk);
    end
    n_checks++;
    if (addr_q.size() + inst_q.size() != 0)
      $display("FAIL drain got %0d pending exp 0", addr_q.size() + inst_q.size());
    else n_pass++;
  endtask

  task automatic test_reset();
    @(posedge clk); #2;
    rstn = 1'b0; inst_ready = 1'b1; redir_valid = 1'b0; redir_pc = 32'h0000_0000;
    gnt_en = 1'b1; rvalid_en = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.imem_req !== 1'b0) $display("FAIL rst_req got %b exp 0", bus.imem_req); else n_pass++;
    n_checks++; if (inst_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", inst_valid); else n_pass++;
    n_checks++; if (inst_out !== 32'h0) $display("FAIL rst_inst_out got %h exp 0", inst_out); else n_pass++;
    n_checks++; if (inst_pc !== 32'h0) $display("FAIL rst_inst_pc got %h exp 0", inst_pc); else n_pass++;
    n_checks++; if (pc_out !== 32'h0) $display("FAIL rst_pc got %h exp 0", pc_out); else n_pass++;
    n_checks++; if (misalign_err !== 1'b0) $display("FAIL rst_err got %b exp 0", misalign_err); else n_pass++;
    n_checks++; if (pc_out2 !== 32'hFFFF_FFFC) $display("FAIL rst_pc2 got %h exp fffffffc", pc_out2); else n_pass++;
  endtask

  task automatic test_stream();
    bit exp_v[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    bit exp_r[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    do_reset(1'b1);
    addr_q.push_back(32'h0); addr_q.push_back(32'h4); addr_q.push_back(32'h8);
    inst_q.push_back(mk(32'h0)); inst_q.push_back(mk(32'h4)); inst_q.push_back(mk(32'h8));
    for (int k = 0; k < 7; k++) begin
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (inst_valid !== exp_v[k]) $display("FAIL stream_valid c%0d got %b exp %b", k + 1, inst_valid, exp_v[k]);
      else n_pass++;
      n_checks++;
      if (bus.imem_req !== exp_r[k]) $display("FAIL stream_req c%0d got %b exp %b", k + 1, bus.imem_req, exp_r[k]);
      else n_pass++;
    end
    n_checks++; if (pc_out !== 32'hC) $display("FAIL stream_pc got %h exp c", pc_out); else n_pass++;
    wait_drain(20);
  endtask

  task automatic test_stall();
    do_reset(1'b0);
    addr_q.push_back(32'h0); addr_q.push_back(32'h4);
    inst_q.push_back(mk(32'h0)); inst_q.push_back(mk(32'h4));
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (inst_valid !== 1'b1) $display("FAIL stall_first got %b exp 1", inst_valid); else n_pass++;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++; if (bus.imem_req !== 1'b0) $display("FAIL stall_req got %b exp 0", bus.imem_req); else n_pass++;
      n_checks++; if (inst_pc !== 32'h0) $display("FAIL stall_pc got %h exp 0", inst_pc); else n_pass++;
      n_checks++; if (inst_out !== mem_word(32'h0)) $display("FAIL stall_out got %h exp %h", inst_out, mem_word(32'h0)); else n_pass++;
      n_checks++; if (pc_out !== 32'h4) $display("FAIL stall_pcout got %h exp 4", pc_out); else n_pass++;
    end
    @(posedge clk); #2;
    inst_ready = 1'b1;
    wait_drain(20);
  endtask

  task automatic test_redir_wait();
    do_reset(1'b1);
    rvalid_en = 1'b0;
    addr_q.push_back(32'h0); addr_q.push_back(32'h100);
    inst_q.push_back(mk(32'h100));
    @(posedge clk);
    @(posedge clk); #2;
    redir_valid = 1'b1; redir_pc = 32'h100;
    @(posedge clk); #2;
    redir_valid = 1'b0; rvalid_en = 1'b1;
    @(negedge clk);
    n_checks++; if (inst_valid !== 1'b0) $display("FAIL rw_valid got %b exp 0", inst_valid); else n_pass++;
    n_checks++; if (pc_out !== 32'h100) $display("FAIL rw_pc got %h exp 100", pc_out); else n_pass++;
    n_checks++; if (bus.imem_req !== 1'b0) $display("FAIL rw_kill_req got %b exp 0", bus.imem_req); else n_pass++;
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (inst_valid !== 1'b0) $display("FAIL rw_drop got %b exp 0", inst_valid); else n_pass++;
    n_checks++; if (bus.imem_req !== 1'b1) $display("FAIL rw_req got %b exp 1", bus.imem_req); else n_pass++;
    wait_drain(20);
  endtask

  task automatic test_redir_rvalid();
    do_reset(1'b1);
    addr_q.push_back(32'h0); addr_q.push_back(32'h4); addr_q.push_back(32'h8); addr_q.push_back(32'h200);
    inst_q.push_back(mk(32'h0)); inst_q.push_back(mk(32'h4)); inst_q.push_back(mk(32'h200));
    repeat (6) @(posedge clk);
    #2;
    redir_valid = 1'b1; redir_pc = 32'h200;
    @(posedge clk); #2;
    redir_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (inst_valid !== 1'b0) $display("FAIL rr_valid got %b exp 0", inst_valid); else n_pass++;
    n_checks++; if (bus.imem_req !== 1'b1) $display("FAIL rr_req got %b exp 1", bus.imem_req); else n_pass++;
    n_checks++; if (pc_out !== 32'h200) $display("FAIL rr_pc got %h exp 200", pc_out); else n_pass++;
    wait_drain(20);
  endtask

  task automatic test_wrap();
    do_reset(1'b1);
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (bus2.imem_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_addr got %h exp fffffffc", bus2.imem_addr); else n_pass++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (pc_out2 !== 32'h0) $display("FAIL wrap_pc got %h exp 0", pc_out2); else n_pass++;
    n_checks++; if (inst_pc2 !== 32'hFFFF_FFFC) $display("FAIL wrap_inst_pc got %h exp fffffffc", inst_pc2); else n_pass++;
    n_checks++; if (inst_out2 !== mem_word(32'hFFFF_FFFC)) $display("FAIL wrap_out got %h exp %h", inst_out2, mem_word(32'hFFFF_FFFC)); else n_pass++;
    n_checks++; if (inst_valid2 !== 1'b1) $display("FAIL wrap_valid got %b exp 1", inst_valid2); else n_pass++;
  endtask

  task automatic test_misalign();
    do_reset(1'b1);
    gnt_en = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    redir_valid = 1'b1; redir_pc = 32'h102;
    @(posedge clk); #2;
    redir_valid = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
    @(negedge clk);
    n_checks++; if (misalign_err !== 1'b1) $display("FAIL mis_err got %b exp 1", misalign_err); else n_pass++;
    n_checks++; if (pc_out !== 32'h0) $display("FAIL mis_pc got %h exp 0", pc_out); else n_pass++;
    n_checks++; if (bus.imem_req !== 1'b0) $display("FAIL mis_req got %b exp 0", bus.imem_req); else n_pass++;
    @(posedge clk); #2;
    gnt_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_checks++; if (misalign_err !== 1'b0) $display("FAIL mis_pulse got %b exp 0", misalign_err); else n_pass++;
      n_checks++; if (bus.imem_req !== 1'b0) $display("FAIL mis_halt got %b exp 0", bus.imem_req); else n_pass++;
    end
`else
    @(negedge clk);
    n_checks++; if (pc_out !== 32'h100) $display("FAIL mis_pc got %h exp 100", pc_out); else n_pass++;
    n_checks++; if (misalign_err !== 1'b0) $display("FAIL mis_err got %b exp 0", misalign_err); else n_pass++;
    @(posedge clk); #2;
    addr_q.push_back(32'h100);
    inst_q.push_back(mk(32'h100));
    gnt_en = 1'b1;
    wait_drain(20);
`endif
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rstn = 1'b0; inst_ready = 1'b1; redir_valid = 1'b0; redir_pc = 32'h0000_0000;
    gnt_en = 1'b1; rvalid_en = 1'b1;
    test_reset();
    test_stream();
    test_stall();
    test_redir_wait();
    test_redir_rvalid();
    test_wrap();
    test_misalign();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
